// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared state encoding and sum width for the sum accumulator
package sum_acc_pkg;

    // ACC collects sums, HOLD presents the finished batch downstream
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Upstream four-bit adder result including its carry-out
    localparam int SUM_WIDTH = 5;

endpackage

// File: rtl/sum_acc_counter.sv
// rtl/sum_acc_counter.sv - 8-bit batch counter with increment, clear and terminal count
module sum_acc_counter #(
    parameter int BATCH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clear,
    output logic tc
);

    localparam logic [7:0] BATCH_C = 8'(BATCH);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear wins over increment; otherwise count accepted sums
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (inc) begin
            count_d = count_q + 8'd1;
        end
    end

    // Terminal count flags the increment that brings the count to BATCH
    assign tc = inc && ((count_q + 8'd1) == BATCH_C);

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - batch accumulator of 5-bit sums; SUM_ACC_SATURATE_EN selects saturation over wrap
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int ACC_WIDTH = 8,
    parameter int BATCH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SUM_WIDTH-1:0]  in_sum,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  out_acc,
    output logic                  out_ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    state_t               state_q;
    state_t               state_d;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 ovf_q;
    logic                 ovf_d;

    logic                 accept;
    logic                 take;
    logic                 batch_done;
    logic [ACC_WIDTH:0]   sum_ext;

    // Input is only taken while collecting; the result only leaves while holding,
    // so a drain and an accept can never share a cycle
    assign accept = in_valid && (state_q == ACC);
    assign take   = out_ready && (state_q == HOLD);

    // One carry bit above the accumulator catches overflow of this addition
    assign sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - SUM_WIDTH){1'b0}}, in_sum};

    sum_acc_counter #(
        .BATCH (BATCH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .clear (take),
        .tc    (batch_done)
    );

    // Next-state, accumulator and sticky overflow update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (take) begin
            state_d = ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
`ifdef SUM_ACC_SATURATE_EN
            acc_d = sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
            acc_d = sum_ext[ACC_WIDTH-1:0];
`endif
            ovf_d = ovf_q | sum_ext[ACC_WIDTH];
            if (batch_done) begin
                state_d = HOLD;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - randomized and directed check of sum_accumulator against a batch-sum model
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] in_sum = 5'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy8, ovf8, val8;
    logic [7:0] acc8;
    logic       rdy6, ovf6, val6;
    logic [5:0] acc6;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: true integer total of the batch, how many sums taken, and whether a result is pending
    int m_total = 0;
    int m_count = 0;
    bit m_hold  = 1'b0;

    always #5 clk = ~clk;

    sum_accumulator #(.ACC_WIDTH(8), .BATCH(4)) dut (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid), .in_ready(rdy8),
        .out_acc(acc8), .out_ovf(ovf8), .out_valid(val8), .out_ready(out_ready)
    );

    sum_accumulator #(.ACC_WIDTH(6), .BATCH(4)) dut6 (
        .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid), .in_ready(rdy6),
        .out_acc(acc6), .out_ovf(ovf6), .out_valid(val6), .out_ready(out_ready)
    );

    function automatic int exp_acc(int total, int w);
`ifdef SUM_ACC_SATURATE_EN
        return (total >= (1 << w)) ? (1 << w) - 1 : total;
`else
        return total % (1 << w);
`endif
    endfunction

    function automatic int exp_ovf(int total, int w);
        return (total >= (1 << w)) ? 1 : 0;
    endfunction

    task automatic chk(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_total = 0;
            m_count = 0;
            m_hold  = 1'b0;
        end else if (!m_hold) begin
            if (in_valid) begin
                m_total = m_total + int'(in_sum);
                m_count = m_count + 1;
                if (m_count == 4) m_hold = 1'b1;
            end
        end else if (out_ready) begin
            m_hold  = 1'b0;
            m_total = 0;
            m_count = 0;
        end
    end

    always @(negedge clk) begin
        chk("acc8",   int'(acc8), exp_acc(m_total, 8));
        chk("ovf8",   int'(ovf8), exp_ovf(m_total, 8));
        chk("valid8", int'(val8), int'(m_hold));
        chk("ready8", int'(rdy8), int'(!m_hold));
        chk("acc6",   int'(acc6), exp_acc(m_total, 6));
        chk("ovf6",   int'(ovf6), exp_ovf(m_total, 6));
        chk("valid6", int'(val6), int'(m_hold));
        chk("ready6", int'(rdy6), int'(!m_hold));
    end

    task automatic drive(bit v, int s, bit r);
        in_valid  = v;
        in_sum    = s[4:0];
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_acc", int'(acc8), 0);
        chk("rst_ovf", int'(ovf8), 0);
        chk("rst_valid", int'(val8), 0);
        chk("rst_ready", int'(rdy8), 1);
        rst = 1'b0;

        drive(1, 3, 1); drive(1, 5, 1); drive(1, 7, 1);
        chk("b2b_not_yet_valid", int'(val8), 0);
        drive(1, 9, 1);
        chk("b2b_valid", int'(val8), 1);
        chk("b2b_acc", int'(acc8), 24);
        chk("b2b_ovf", int'(ovf8), 0);
        drive(0, 0, 1);
        chk("b2b_one_cycle", int'(val8), 0);
        chk("b2b_cleared", int'(acc8), 0);

        drive(1, 1, 1); drive(0, 0, 1); drive(1, 2, 1); drive(0, 0, 1);
        drive(1, 3, 1); drive(0, 0, 1); drive(1, 4, 1);
        chk("gap_valid", int'(val8), 1);
        chk("gap_acc", int'(acc8), 10);
        drive(0, 0, 1);

        for (int i = 0; i < 4; i++) drive(1, 7, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 7, 0);
            chk("stall_ready", int'(rdy8), 0);
            chk("stall_acc", int'(acc8), 28);
        end
        drive(1, 7, 1);
        chk("release_ready", int'(rdy8), 1);
        chk("release_acc", int'(acc8), 0);

        for (int i = 0; i < 4; i++) drive(1, 1, 1);
        chk("drain_pre_acc", int'(acc8), 4);
        drive(1, 9, 1);
        chk("drain_no_accept", int'(acc8), 0);
        drive(1, 2, 1);
        chk("next_batch_start", int'(acc8), 2);
        for (int i = 0; i < 3; i++) drive(1, 0, 1);
        drive(0, 0, 1);

        for (int i = 0; i < 4; i++) drive(1, 31, 0);
`ifdef SUM_ACC_SATURATE_EN
        chk("w6_acc", int'(acc6), 63);
`else
        chk("w6_acc", int'(acc6), 60);
`endif
        chk("w6_ovf", int'(ovf6), 1);
        chk("w8_acc", int'(acc8), 124);
        chk("w8_ovf", int'(ovf8), 0);
        drive(0, 0, 1);

        drive(1, 10, 1); drive(1, 10, 1);
        chk("pre_rst_acc", int'(acc8), 20);
        rst = 1'b1;
        #1;
        chk("mid_rst_acc", int'(acc8), 0);
        chk("mid_rst_ready", int'(rdy8), 1);
        drive(1, 5, 1);
        chk("rst_hold_acc", int'(acc8), 0);
        chk("rst_hold_valid", int'(val8), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1, 1, 1);
        chk("post_rst_acc", int'(acc8), 4);
        chk("post_rst_valid", int'(val8), 1);
        drive(0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                drive(1, 31, 1);
                rst = 1'b0;
            end
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                  bit'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 8, accumulator width in bits; legal range 5..32.
REQ-002 SHALL have parameter BATCH, default 4, number of sums per result; legal range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_sum  input  5  unsigned 5-bit sum from the upstream four-bit adder (carry in bit 4).
REQ-006 SHALL have port in_valid  input  1  in_sum is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts in_sum this cycle.
REQ-008 SHALL have port out_acc  output  ACC_WIDTH  accumulated batch result.
REQ-009 SHALL have port out_ovf  output  1  batch overflowed ACC_WIDTH.
REQ-010 SHALL have port out_valid  output  1  out_acc/out_ovf hold a completed batch.
REQ-011 SHALL have port out_ready  input  1  downstream takes the result this cycle.

Function
REQ-012 SHALL implement two states: ACC (collecting) and HOLD (presenting result).
REQ-013 SHALL drive in_ready=1 exactly in ACC and out_valid=1 exactly in HOLD.
REQ-014 SHALL accept a sum only on in_valid&&in_ready; the accumulator adds in_sum zero-extended to ACC_WIDTH+1 bits, and the count increments.
REQ-015 SHALL ignore in_sum whenever in_valid=0; gaps do not advance the count.
REQ-016 SHALL, on the accept that makes count equal BATCH, enter HOLD; out_valid rises the next cycle with the final sum (latency 1 cycle from last accept).
REQ-017 SHALL hold out_acc and out_ovf stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-018 SHALL, on out_valid&&out_ready, clear the accumulator, count and overflow flag and return to ACC; in_ready is 1 the following cycle.
REQ-019 SHALL NOT accept input in the cycle the result is taken (no same-cycle drain and accept).
REQ-020 SHALL set out_ovf sticky for the batch when any addition carries out of ACC_WIDTH bits.
REQ-021 SHALL keep out_acc visible during ACC as the running partial sum, with out_valid=0.

Reset
REQ-022 SHALL, while rst=1, force state ACC, accumulator 0, count 0, out_ovf 0, out_valid 0, in_ready 1.
REQ-023 SHALL ignore any handshake while rst=1; reset mid-batch or during HOLD discards the partial or pending result.

Configuration
REQ-024 SHALL, with SUM_ACC_SATURATE_EN defined, clamp the accumulator at all-ones on overflow, and set out_ovf.
REQ-025 SHALL, without SUM_ACC_SATURATE_EN, wrap the accumulator modulo 2^ACC_WIDTH, and set out_ovf.

Structure
REQ-026 SHALL place the state enum (ACC, HOLD) and the constant SUM_WIDTH=5 in shared package sum_acc_pkg.
REQ-027 SHALL implement the batch count as one sub-module, sum_acc_counter: 8-bit counter with inc, clear and terminal-count output at BATCH.

Verification (ACC_WIDTH=8, BATCH=4 unless stated)
REQ-028 SHALL test back-to-back 3,5,7,9 with out_ready=1 -> out_valid for one cycle, one cycle after the 4th accept; out_acc=24, out_ovf=0.
REQ-029 SHALL test 1,2,3,4 with in_valid low one cycle between each -> out_acc=10; idle cycles not counted.
REQ-030 SHALL test a completed batch with out_ready=0 for 5 cycles while in_valid=1, in_sum=7 -> in_ready=0, out_acc constant; after out_ready=1 -> next cycle in_ready=1, out_acc=0.
REQ-031 SHALL test ACC_WIDTH=6 with 31,31,31,31 -> out_acc=60, out_ovf=1 without the macro; out_acc=63, out_ovf=1 with SUM_ACC_SATURATE_EN.
REQ-032 SHALL test reset asserted after 2 accepts (sums 10,10) then a batch of 1,1,1,1 -> all outputs 0 during reset; then out_acc=4.
REQ-033 SHALL test in_valid=1, in_sum=9 in the cycle out_valid&&out_ready -> 9 not accumulated; next batch starts from 0.
